// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - FIFO controller driving a dual-port RAM (write/read on the negedge)
module dpram_fifo_ctrl #(
   parameter int ADDR_WIDTH    = 10,
   parameter int AFULL_THRESH  = 1020,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic                  i_err_clr,
   output logic                  o_ram_wen,
   output logic [ADDR_WIDTH-1:0] o_ram_waddr,
   output logic                  o_ram_ren,
   output logic [ADDR_WIDTH-1:0] o_ram_raddr,
   output logic                  o_rd_valid,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam int                DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] C_DEPTH  = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] C_AFULL  = AFULL_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] C_AEMPTY = AEMPTY_THRESH[ADDR_WIDTH:0];

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_afull;
   logic                  r_aempty;
   logic                  r_rd_valid;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_push_ok;
   logic                  w_pop_ok;
   logic [ADDR_WIDTH:0]   w_count_nxt;

   // Flags are registered from next-count so push/pop see a single gate to the RAM strobes.
   assign w_push_ok = i_push & ~r_full & i_rst_n;
   assign w_pop_ok  = i_pop & ~r_empty & i_rst_n;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push_ok, w_pop_ok})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_afull     <= 1'b0;
         r_aempty    <= 1'b1;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count     <= w_count_nxt;
         r_full      <= (w_count_nxt == C_DEPTH);
         r_empty     <= (w_count_nxt == '0);
         r_afull     <= (w_count_nxt >= C_AFULL);
         r_aempty    <= (w_count_nxt <= C_AEMPTY);
         r_rd_valid  <= w_pop_ok;
         // A new error in the same cycle as err_clr keeps the flag set.
         r_overflow  <= (i_push & r_full)  | (r_overflow  & ~i_err_clr);
         r_underflow <= (i_pop  & r_empty) | (r_underflow & ~i_err_clr);
      end
   end

   assign o_ram_wen      = w_push_ok;
   assign o_ram_waddr    = r_wr_ptr;
   assign o_ram_ren      = w_pop_ok;
   assign o_ram_raddr    = r_rd_ptr;
   assign o_rd_valid     = r_rd_valid;
   assign o_full         = r_full;
   assign o_empty        = r_empty;
   assign o_almost_full  = r_afull;
   assign o_almost_empty = r_aempty;
   assign o_count        = r_count;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - randomized bench for dpram_fifo_ctrl against a queue model and RAM model
module tb_dpram_fifo_ctrl;

   localparam int AW    = 10;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          push;
   logic          pop;
   logic          err_clr;
   logic [31:0]   wdata;

   logic          ram_wen;
   logic [AW-1:0] ram_waddr;
   logic          ram_ren;
   logic [AW-1:0] ram_raddr;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   always #5 clk = ~clk;

   dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(1020), .AEMPTY_THRESH(4)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_push         (push),
      .i_pop          (pop),
      .i_err_clr      (err_clr),
      .o_ram_wen      (ram_wen),
      .o_ram_waddr    (ram_waddr),
      .o_ram_ren      (ram_ren),
      .o_ram_raddr    (ram_raddr),
      .o_rd_valid     (rd_valid),
      .o_full         (full),
      .o_empty        (empty),
      .o_almost_full  (almost_full),
      .o_almost_empty (almost_empty),
      .o_count        (count),
      .o_overflow     (overflow),
      .o_underflow    (underflow)
   );

   // Behavioural 32x1024 RAM acting on the falling edge
   logic [31:0] mem [DEPTH];
   logic [31:0] d_out;
   always @(negedge clk) begin
      if (ram_wen) mem[ram_waddr] <= wdata;
      if (ram_ren) d_out <= mem[ram_raddr];
   end

   // Reference model
   logic [31:0] q[$];
   int          m_wcnt;
   int          m_rcnt;
   bit          m_ovf;
   bit          m_unf;
   bit          m_rdv;
   logic [31:0] m_dout;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_wcnt = 0;
      m_rcnt = 0;
      m_ovf  = 0;
      m_unf  = 0;
      m_rdv  = 0;
   endtask

   task automatic check_state();
      int n;
      n = q.size();
      chk("count", 64'(count), 64'(n));
      chk("full", 64'(full), 64'(n == DEPTH));
      chk("empty", 64'(empty), 64'(n == 0));
      chk("almost_full", 64'(almost_full), 64'(n >= 1020));
      chk("almost_empty", 64'(almost_empty), 64'(n <= 4));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("underflow", 64'(underflow), 64'(m_unf));
      chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
      if (m_rdv) chk("d_out", 64'(d_out), 64'(m_dout));
   endtask

   // Entered and left at posedge+1
   task automatic step(input bit p, input bit r, input bit c, input logic [31:0] d);
      bit wok;
      bit pok;
      push = p; pop = r; err_clr = c; wdata = d;
      wok = p && (q.size() < DEPTH);
      pok = r && (q.size() > 0);
      #1;
      chk("ram_wen", 64'(ram_wen), 64'(wok));
      chk("ram_ren", 64'(ram_ren), 64'(pok));
      if (wok) chk("ram_waddr", 64'(ram_waddr), 64'(m_wcnt % DEPTH));
      if (pok) chk("ram_raddr", 64'(ram_raddr), 64'(m_rcnt % DEPTH));
      @(posedge clk);
      if (p && !wok) m_ovf = 1; else if (c) m_ovf = 0;
      if (r && !pok) m_unf = 1; else if (c) m_unf = 0;
      m_rdv = pok;
      if (pok) begin m_dout = q.pop_front(); m_rcnt++; end
      if (wok) begin q.push_back(d); m_wcnt++; end
      #1;
      check_state();
   endtask

   initial begin
      rst_n = 1'b0; push = 1'b1; pop = 1'b1; err_clr = 1'b0; wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ram_wen", 64'(ram_wen), 64'd0);
      chk("reset_ram_ren", 64'(ram_ren), 64'd0);
      check_state();
      push = 1'b0; pop = 1'b0;
      rst_n = 1'b1;

      // Fill, overflow, simultaneous at full, drain in order
      for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 32'(i));
      step(1, 0, 0, 32'hDEAD_BEEF);
      step(1, 1, 0, 32'h1111_2222);
      chk("full_simul_count", 64'(count), 64'd1023);
      step(1, 0, 0, 32'h3333_4444);
      while (q.size() > 0) step(0, 1, 0, '0);
      step(0, 0, 0, '0);

      // Simultaneous at empty, sticky underflow
      step(1, 1, 0, 32'h5555_6666);
      chk("empty_simul_count", 64'(count), 64'd1);
      repeat (10) step(0, 0, 0, '0);
      step(0, 0, 1, '0);
      step(0, 1, 0, '0);
      step(0, 1, 1, '0);
      chk("clr_vs_set_underflow", 64'(underflow), 64'd1);
      step(0, 0, 1, '0);

      // Wrap-around with low occupancy
      repeat (3) step(1, 0, 0, $urandom);
      for (int i = 0; i < 1500; i++) begin
         step(1, 1, 0, $urandom);
         chk("wrap_count_le4", 64'(count <= 4), 64'd1);
      end
      while (q.size() > 0) step(0, 1, 0, '0);

      // Simultaneous at 500
      repeat (500) step(1, 0, 0, $urandom);
      step(1, 1, 0, $urandom);
      chk("mid_simul_count", 64'(count), 64'd500);

      // Reset mid-stream at 700 during a pop
      repeat (201) step(1, 0, 0, $urandom);
      step(0, 1, 0, '0);
      push = 1'b0; pop = 1'b1; err_clr = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_count", 64'(count), 64'd0);
      chk("midrst_rd_valid", 64'(rd_valid), 64'd0);
      chk("midrst_ram_ren", 64'(ram_ren), 64'd0);
      chk("midrst_empty", 64'(empty), 64'd1);
      @(posedge clk);
      #1;
      pop = 1'b0;
      rst_n = 1'b1;
      step(1, 0, 0, 32'hA5A5_A5A5);
      step(0, 1, 0, '0);
      chk("a5_d_out", 64'(d_out), 64'hA5A5_A5A5);

      // Random traffic, including runs biased toward full and empty
      for (int blk = 0; blk < 6; blk++) begin
         int pw;
         int pr;
         pw = (blk % 2 == 0) ? 90 : 20;
         pr = (blk % 2 == 0) ? 20 : 90;
         for (int i = 0; i < 700; i++) begin
            step(($urandom % 100) < pw, ($urandom % 100) < pr, ($urandom % 50) == 0, $urandom);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of the 32x1024 dual-port RAM and turns it into a first-in/first-out buffer. It accepts push/pop requests from the fabric side on the rising edge of `clk` and produces the RAM's `wen`, `ren`, `waddr` and `raddr`. The RAM performs its write and registered read on the following falling edge of the same clock. The block keeps the occupancy count, full/empty and programmable almost-full/almost-empty flags, sticky overflow/underflow errors, and a read-data-valid strobe that qualifies the RAM's `d_out`.

## Interface
- `ADDR_WIDTH`, 10: RAM address width. Depth is 2^ADDR_WIDTH = 1024.
- `AFULL_THRESH`, 1020: `almost_full` asserts when `count >= AFULL_THRESH`.
- `AEMPTY_THRESH`, 4: `almost_empty` asserts when `count <= AEMPTY_THRESH`.

Ports:
- `clk` in 1: single clock. Controller state updates on posedge; the RAM acts on negedge of the same `clk`.
- `rst_n` in 1: asynchronous, active-low reset. Assertion is immediate; release is on a posedge.
- `push` in 1: write request for the current cycle.
- `pop` in 1: read request for the current cycle.
- `ram_wen` out 1: to RAM `wen`.
- `ram_waddr` out ADDR_WIDTH: to RAM `waddr`.
- `ram_ren` out 1: to RAM `ren`.
- `ram_raddr` out ADDR_WIDTH: to RAM `raddr`.
- `rd_valid` out 1: RAM `d_out` holds the word of the most recently accepted pop.
- `full` out 1: `count == 1024`.
- `empty` out 1: `count == 0`.
- `almost_full` out 1: see `AFULL_THRESH`.
- `almost_empty` out 1: see `AEMPTY_THRESH`.
- `count` out ADDR_WIDTH+1: occupancy, range 0..1024.
- `overflow` out 1: sticky; set by a push while full.
- `underflow` out 1: sticky; set by a pop while empty.
- `err_clr` in 1: synchronous clear of both sticky flags.

## Operation
- **Registers:**
  - `wr_ptr` and `rd_ptr`, ADDR_WIDTH bits each. They wrap modulo 2^ADDR_WIDTH, i.e. 1023 -> 0.
  - `count`, ADDR_WIDTH+1 bits.
  - `rd_valid`, `overflow`, `underflow`.
- **Accept logic (combinational):**
  - `push_ok = push & ~full`
  - `pop_ok = pop & ~empty`
  - Full/empty decisions use the registered `count` only; there is no same-cycle bypass.
- **RAM drive (combinational from registers and requests):**
  - `ram_wen = push_ok`, `ram_waddr = wr_ptr`
  - `ram_ren = pop_ok`, `ram_raddr = rd_ptr`
- **On posedge:**
  - If `push_ok`: `wr_ptr++`.
  - If `pop_ok`: `rd_ptr++`.
  - `count` changes by +1 (`push_ok` only), -1 (`pop_ok` only), or 0 (neither, or both).
  - `rd_valid <= pop_ok`.
- **Simultaneous events:**
  - Push+pop while empty: push accepted, pop rejected with `underflow` set. Next state: `count` = 1.
  - Push+pop while full: pop accepted, push rejected with `overflow` set. Next state: `count` = 1023.
  - Push+pop otherwise: both accepted, `count` unchanged.
- **Sticky errors:**
  - `overflow` <= 1 on `push & full`; `underflow` <= 1 on `pop & empty`.
  - `err_clr` clears both. If a set and `err_clr` occur in the same cycle, set wins.
- **Flags:** `full`, `empty`, `almost_full` and `almost_empty` are decoded from registered `count`.
- **Reset (`rst_n` = 0):**
  - Pointers = 0, `count` = 0.
  - `empty` = 1, `almost_empty` = 1.
  - `full`, `almost_full`, `rd_valid`, `overflow`, `underflow` = 0.
  - `ram_wen` = `ram_ren` = 0 while in reset (requests are masked).
  - Reset asserted mid-operation discards all contents. RAM array contents are not cleared and are never observable afterwards.

## Timing
- **Write:** a push accepted in cycle N (posedge N to N+1) is written by the RAM at the negedge inside cycle N.
- **Flag update after push:** `count` and `empty` update at posedge N+1.
- **Read-after-write:** a pop in cycle N+1 returns that word. Minimum write-to-read turnaround is 1 cycle.
- **Read:** a pop accepted in cycle N is captured by the RAM on `d_out` at the negedge inside cycle N.
  - `rd_valid` = 1 during cycle N+1, so the consumer samples `d_out` at posedge N+2 qualified by `rd_valid`.
  - `d_out` holds its value until the next accepted pop.
- **Timing path:** `ram_wen`, `ram_ren` and the addresses must settle within half a clock period (posedge to negedge). Keep the `push`/`pop` input paths shallow.
- **Throughput:** one push and one pop per cycle, sustained.

## Test plan
- **Reset:** hold `rst_n` = 0 with `push` = `pop` = 1 -> `ram_wen` = `ram_ren` = 0, `empty` = 1, `count` = 0. Release -> first push drives `ram_waddr` = 0.
- **Fill and drain:** push 1024 words 0..1023.
  - `full` rises at posedge after the 1024th push; `almost_full` rises when `count` reaches 1020.
  - 1025th push -> `ram_wen` = 0, `overflow` = 1.
  - Pop 1024 -> `d_out` returns 0..1023 in order, each with `rd_valid`. `empty` = 1 at end.
- **Wrap-around:** push and pop 1500 words with occupancy around 3 -> `ram_waddr` and `ram_raddr` pass 1023 -> 0, data order preserved, `count` never exceeds 4.
- **Simultaneous push+pop at boundaries:**
  - At `count` = 0 -> `count` becomes 1, `underflow` = 1.
  - At `count` = 1024 -> `count` becomes 1023, `overflow` = 1.
  - At `count` = 500 -> `count` stays 500.
- **Sticky flags:**
  - Trigger `underflow`, then idle 10 cycles -> flag stays 1.
  - `err_clr` alone -> cleared.
  - `err_clr` with `pop & empty` in the same cycle -> stays 1.
- **Reset mid-stream:** assert `rst_n` = 0 at `count` = 700 during a pop -> `count` = 0, `rd_valid` = 0 immediately. After release, push A5A5A5A5 then pop -> `d_out` = A5A5A5A5 with `rd_valid`.
